// File: rtl/alu_pkg.sv
// Shared types and mode encodings for the pipelined ALU.
// Unit select, per-unit mode codes and sequencer state.
package alu_pkg;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_SHIFT = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_LOGIC = 2'b11
  } unit_e;

  localparam logic [1:0] ARITH_ADD = 2'b00;
  localparam logic [1:0] ARITH_SUB = 2'b01;
  localparam logic [1:0] ARITH_MUL = 2'b10;
  localparam logic [1:0] ARITH_INC = 2'b11;

  localparam logic [1:0] SHL = 2'b00;
  localparam logic [1:0] SHR = 2'b01;
  localparam logic [1:0] ROL = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  localparam logic [1:0] CMP_EQ  = 2'b00;
  localparam logic [1:0] CMP_LTU = 2'b01;
  localparam logic [1:0] CMP_LTS = 2'b10;
  localparam logic [1:0] CMP_MAX = 2'b11;

  localparam logic [1:0] LOG_AND = 2'b00;
  localparam logic [1:0] LOG_OR  = 2'b01;
  localparam logic [1:0] LOG_XOR = 2'b10;
  localparam logic [1:0] LOG_NOT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one partial product per clock.
// Ports: start loads X/Y; done flags the last step; product is valid with done.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               act_q, act_d;
  logic [2*WIDTH-1:0] step;

  // Accumulator after this cycle's step; on the last step it is the product.
  assign step    = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign done    = act_q && (cnt_q == CW'(WIDTH - 1));
  assign product = step;

  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    if (start) begin
      mcand_d = {{WIDTH{1'b0}}, X};
      mplr_d  = Y;
      acc_d   = '0;
      cnt_d   = '0;
      act_d   = 1'b1;
    end else if (act_q) begin
      acc_d   = step;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q + CW'(1);
      if (done) act_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      act_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: arith/shift/compare/logic units plus iterative multiply.
// Ports: in_valid/in_ready + X,Y,s,m in; out_valid/out_ready + Z,zero out; busy.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  input  logic [1:0]         s,
  input  logic [1:0]         m,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Z,
  output logic               zero,
  output logic               busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic               zero_q, zero_d;
  logic               ov_q, ov_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [2*WIDTH-1:0] res;

  logic [WIDTH:0]     add_r, inc_r;
  logic [WIDTH-1:0]   sub_r;
  logic [SHW-1:0]     amt, inv;
  logic [WIDTH-1:0]   rol_r, ror_r;

  assign in_ready  = (state_q == IDLE) && (!ov_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (s == UNIT_ARITH) && (m == ARITH_MUL);
  assign out_valid = ov_q;
  assign Z         = z_q;
  assign zero      = zero_q;
  assign busy      = busy_q;

  assign add_r = {1'b0, X} + {1'b0, Y};
  assign inc_r = {1'b0, X} + {1'b0, ONE};
  assign sub_r = X - Y;

  // Rotates: the complementary shift uses (-amt) mod WIDTH, so amt=0 is X.
  assign amt   = Y[SHW-1:0];
  assign inv   = SHW'(0) - amt;
  assign rol_r = (X << amt) | (X >> inv);
  assign ror_r = (X >> amt) | (X << inv);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .X       (X),
    .Y       (Y),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    res = '0;
    unique case (unit_e'(s))
      UNIT_ARITH:
        unique case (m)
          ARITH_ADD: res = {{(WIDTH-1){1'b0}}, add_r};
          ARITH_SUB: res = {{WIDTH{sub_r[WIDTH-1]}}, sub_r};
          ARITH_MUL: res = '0;
          default:   res = {{(WIDTH-1){1'b0}}, inc_r};
        endcase
      UNIT_SHIFT:
        unique case (m)
          SHL:     res = {{WIDTH{1'b0}}, X << amt};
          SHR:     res = {{WIDTH{1'b0}}, X >> amt};
          ROL:     res = {{WIDTH{1'b0}}, rol_r};
          default: res = {{WIDTH{1'b0}}, ror_r};
        endcase
      UNIT_CMP:
        unique case (m)
          CMP_EQ:  res = {{(2*WIDTH-1){1'b0}}, X == Y};
          CMP_LTU: res = {{(2*WIDTH-1){1'b0}}, X < Y};
          CMP_LTS: res = {{(2*WIDTH-1){1'b0}}, $signed(X) < $signed(Y)};
          default: res = {{WIDTH{1'b0}}, (X > Y) ? X : Y};
        endcase
      default:
        unique case (m)
          LOG_AND: res = {{WIDTH{1'b0}}, X & Y};
          LOG_OR:  res = {{WIDTH{1'b0}}, X | Y};
          LOG_XOR: res = {{WIDTH{1'b0}}, X ^ Y};
          default: res = {{WIDTH{1'b0}}, ~X};
        endcase
    endcase
  end

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    zero_d  = zero_q;
    ov_d    = ov_q;
    if (out_ready) ov_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && is_mul) begin
          state_d = MUL;
        end else if (accept) begin
          z_d    = res;
          zero_d = (res == '0);
          ov_d   = 1'b1;
        end
      end
      MUL: begin
        if (mul_done) begin
          z_d     = mul_prod;
          zero_d  = (mul_prod == '0);
          ov_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MUL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      z_q     <= '0;
      zero_q  <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe at WIDTH=8.
// Each task drives one scenario and checks results inline.
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  X, Y;
  logic [1:0]  s, m;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Z;
  logic        zero;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .s         (s),
    .m         (m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    X = '0; Y = '0; s = '0; m = '0;
    out_ready = 1'b1;
    #12;
    n_chk++;
    if ({out_valid, busy, zero, Z} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset: ov=%b busy=%b zero=%b Z=%h want 0 0 0 0000",
               out_valid, busy, zero, Z);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_b2b();
    in_valid = 1'b1; X = 8'hFF; Y = 8'h01; s = UNIT_ARITH; m = ARITH_ADD;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL add_ready: in_ready=%b want 1", in_ready);
    end
    tick();
    n_chk++;
    if ({out_valid, zero, Z, in_ready} !== {1'b1, 1'b0, 16'h0100, 1'b1}) begin
      n_fail++;
      $display("FAIL add: ov=%b zero=%b Z=%h rdy=%b want 1 0 0100 1",
               out_valid, zero, Z, in_ready);
    end
    X = 8'h05; Y = 8'h03; m = ARITH_SUB;
    tick();
    n_chk++;
    if ({out_valid, Z} !== {1'b1, 16'h0002}) begin
      n_fail++;
      $display("FAIL sub_b2b: ov=%b Z=%h want 1 0002", out_valid, Z);
    end
    X = 8'h03; Y = 8'h05;
    tick();
    n_chk++;
    if (Z !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL sub_neg: Z=%h want fffe", Z);
    end
    X = 8'hFF; m = ARITH_INC;
    tick();
    n_chk++;
    if ({zero, Z} !== {1'b0, 16'h0100}) begin
      n_fail++;
      $display("FAIL inc: zero=%b Z=%h want 0 0100", zero, Z);
    end
    in_valid = 1'b0;
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_mul(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp);
    in_valid = 1'b1; X = a; Y = b; s = UNIT_ARITH; m = ARITH_MUL;
    tick();
    in_valid = 1'b0; X = 8'h00; Y = 8'h00;
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if ({busy, in_ready, out_valid} !== 3'b100) begin
        n_fail++;
        $display("FAIL mul_busy[%0d]: busy=%b rdy=%b ov=%b want 1 0 0",
                 i, busy, in_ready, out_valid);
      end
      tick();
    end
    n_chk++;
    if ({out_valid, busy, Z, zero} !== {1'b1, 1'b0, exp, 1'b0}) begin
      n_fail++;
      $display("FAIL mul %h*%h: ov=%b busy=%b Z=%h zero=%b want 1 0 %h 0",
               a, b, out_valid, busy, Z, zero, exp);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; X = 8'hAA; Y = 8'hAA; s = UNIT_LOGIC; m = LOG_XOR;
    tick();
    X = 8'h0F; Y = 8'h3C; m = LOG_AND;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if ({out_valid, zero, Z, in_ready} !== {1'b1, 1'b1, 16'h0000, 1'b0}) begin
        n_fail++;
        $display("FAIL hold[%0d]: ov=%b zero=%b Z=%h rdy=%b want 1 1 0000 0",
                 i, out_valid, zero, Z, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_ready: in_ready=%b want 1", in_ready);
    end
    tick();
    n_chk++;
    if ({out_valid, zero, Z} !== {1'b1, 1'b0, 16'h000C}) begin
      n_fail++;
      $display("FAIL pending: ov=%b zero=%b Z=%h want 1 0 000c",
               out_valid, zero, Z);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_shift_logic();
    logic [1:0]  ts [8] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd0};
    logic [1:0]  tm [8] = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd1, 2'd0, 2'd3};
    logic [7:0]  tx [8] = '{8'h81, 8'h80, 8'h81, 8'hA5, 8'h0F, 8'h50, 8'hF0, 8'h7F};
    logic [7:0]  ty [8] = '{8'h09, 8'h07, 8'h01, 8'h08, 8'h00, 8'h05, 8'h0F, 8'h00};
    logic [15:0] te [8] = '{16'h0003, 16'h0001, 16'h0002, 16'h00A5,
                            16'h00F0, 16'h0055, 16'h0000, 16'h0080};
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; X = tx[i]; Y = ty[i]; s = ts[i]; m = tm[i];
      tick();
      n_chk++;
      if ({out_valid, Z, zero} !== {1'b1, te[i], te[i] == 16'h0}) begin
        n_fail++;
        $display("FAIL op[%0d] s=%0d m=%0d: ov=%b Z=%h zero=%b want %h",
                 i, ts[i], tm[i], out_valid, Z, zero, te[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_compare();
    logic [1:0]  tm [4] = '{CMP_LTS, CMP_LTU, CMP_MAX, CMP_EQ};
    logic [15:0] te [4] = '{16'h0001, 16'h0000, 16'h0080, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; X = 8'h80; Y = 8'h01; s = UNIT_CMP; m = tm[i];
      tick();
      n_chk++;
      if ({Z, zero} !== {te[i], te[i] == 16'h0}) begin
        n_fail++;
        $display("FAIL cmp m=%0d: Z=%h zero=%b want %h", tm[i], Z, zero, te[i]);
      end
    end
    in_valid = 1'b1; X = 8'h5A; Y = 8'h5A; m = CMP_EQ;
    tick();
    n_chk++;
    if (Z !== 16'h0001) begin
      n_fail++;
      $display("FAIL cmp_eq_true: Z=%h want 0001", Z);
    end
    X = 8'hC0; Y = 8'hE0; m = CMP_MAX;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    in_valid = 1'b1; X = 8'd15; Y = 8'd17; s = UNIT_ARITH; m = ARITH_MUL;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, busy, Z} !== 18'd0) begin
      n_fail++;
      $display("FAIL mid_reset: ov=%b busy=%b Z=%h want 0 0 0000",
               out_valid, busy, Z);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_ready: in_ready=%b want 1", in_ready);
    end
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if ({out_valid, busy, Z} !== 18'd0) begin
        n_fail++;
        $display("FAIL stale[%0d]: ov=%b busy=%b Z=%h want 0 0 0000",
                 i, out_valid, busy, Z);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add_b2b();
    test_mul(8'd15, 8'd17, 16'd255);
    test_mul(8'hFF, 8'hFF, 16'hFE01);
    test_mul(8'h0D, 8'h0B, 16'h008F);
    test_backpressure();
    test_shift_logic();
    test_compare();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the 8-bit combinational ALU: same four units (arithmetic, shifter/rotator, comparator, logic) selected by s, mode by m.
- Generalised to WIDTH-bit operands with a 2*WIDTH-bit registered result.
- Adds an iterative multi-cycle multiplier and valid/ready flow control so it sits between an operand-issue stage and a writeback stage.

Parameters:
- WIDTH, 8, operand width; power of two, >= 4; result width is 2*WIDTH.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- X  in  WIDTH  operand X.
- Y  in  WIDTH  operand Y.
- s  in  2  unit select: 00 arith, 01 shift, 10 compare, 11 logic.
- m  in  2  mode within unit.
- out_valid  out  1  Z holds a result.
- out_ready  in  1  consumer takes result.
- Z  out  2*WIDTH  registered result.
- zero  out  1  registered, Z == 0 for current result.
- busy  out  1  multiplier iterating.

Behaviour:
- Reset (async, rst_n=0): state IDLE, out_valid=0, Z=0, zero=0, busy=0, multiplier registers cleared. Reset mid-multiply aborts it; no result is produced.
- Accept: the op is accepted on a rising edge with in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back single-cycle ops at full rate.
- Single-cycle ops: result registered at the accept edge; out_valid high from the next cycle (latency 1).
- Multiply (s=00, m=10): at the accept edge, load X and Y into alu_mul_seq, state goes to MUL, busy=1.
  - One shift-add step per edge, WIDTH steps.
  - On the WIDTH-th step edge: Z=product, out_valid=1, state goes to IDLE, busy=0.
  - Latency is WIDTH cycles from accept. in_ready=0 throughout MUL.
- Output hold: while out_valid && !out_ready, Z, zero and out_valid are stable. in_ready=0.
- out_valid clears on the edge with out_ready, unless a new single-cycle op is accepted on the same edge; in that case Z updates and out_valid stays 1.
- Arithmetic unit:
  - 00: X+Y unsigned, carry in bit WIDTH, upper bits 0.
  - 01: X-Y two's complement, sign-extended to 2*WIDTH.
  - 10: X*Y unsigned, multi-cycle.
  - 11: X+1 unsigned, carry in bit WIDTH.
- Shifter unit: shift amount is Y[SHW-1:0]; Y upper bits are ignored. Result is zero-extended to 2*WIDTH.
  - 00: logical left.
  - 01: logical right.
  - 10: rotate left within WIDTH.
  - 11: rotate right within WIDTH.
  - Shift amount 0 returns X unchanged.
- Comparator unit:
  - 00: X==Y.
  - 01: X<Y unsigned.
  - 10: X<Y signed.
  - 11: unsigned max(X,Y), zero-extended.
  - Boolean results appear in bit 0 with other bits 0.
- Logic unit: 00 AND, 01 OR, 10 XOR, 11 NOT X. Results are zero-extended; upper WIDTH bits are 0.
- zero is computed from the value written into Z, in the same edge.
- FSM states:
  - IDLE: goes to MUL on an accepted multiply; otherwise stays IDLE.
  - MUL: goes to IDLE when the step counter reaches WIDTH-1.
  - Illegal state encodings return to IDLE.
- Inputs X, Y, s and m are only sampled at the accept edge; changes during MUL have no effect.

Decomposition:
- alu_pkg holds:
  - unit_e enum: UNIT_ARITH, UNIT_SHIFT, UNIT_CMP, UNIT_LOGIC.
  - Per-unit mode localparams: ARITH_ADD, ARITH_SUB, ARITH_MUL, ARITH_INC, SHL, SHR, ROL, ROR, CMP_EQ, CMP_LTU, CMP_LTS, CMP_MAX, LOG_AND, LOG_OR, LOG_XOR, LOG_NOT.
  - state_e enum: IDLE, MUL.
- Sub-module alu_mul_seq (parameter WIDTH):
  - Ports: start, X, Y, done, product.
  - Shift-add with step counter.
- The combinational single-cycle datapath stays inline in alu_pipe.

Test Plan (WIDTH=8):
- Add, X=8'hFF, Y=8'h01, s=00, m=00, out_ready=1 -> one cycle later out_valid=1, Z=16'h0100, zero=0. Next op accepted back-to-back.
- Multiply, X=8'd15, Y=8'd17 -> busy=1 and in_ready=0 for 8 cycles. Then Z=16'd255, out_valid=1. Also 8'hFF*8'hFF -> 16'hFE01.
- Backpressure: complete XOR X=8'hAA, Y=8'hAA with out_ready=0 for 5 cycles.
  - Required: Z=0 and zero=1 held stable; in_ready=0; a pending in_valid op is not accepted.
  - The pending op is accepted on the edge out_ready rises.
- Shifter: ROL X=8'h81, Y=8'h09 (amount 1) -> Z=16'h0003. SHR X=8'h80, Y=8'h07 -> Z=16'h0001.
- Compare: X=8'h80, Y=8'h01. CMP_LTS -> Z=1. CMP_LTU -> Z=0, zero=1. CMP_MAX -> Z=16'h0080.
- Reset mid-multiply: assert rst_n=0 after 3 multiply steps -> immediately out_valid=0, busy=0, Z=0. After release, in_ready=1 and no stale result appears.
